// File: rtl/mc_control_unit_pkg.sv
// Shared types and encodings for the RV32I multicycle control unit.
package mc_ctrl_pkg;

  // FSM state, also exported on state_o for debug
  typedef enum logic [4:0] {
    ST_FETCH    = 5'd0,
    ST_DECODE   = 5'd1,
    ST_MEM_ADDR = 5'd2,
    ST_MEM_RD   = 5'd3,
    ST_MEM_WR   = 5'd4,
    ST_LD_WB    = 5'd5,
    ST_R_EX     = 5'd6,
    ST_I_EX     = 5'd7,
    ST_ALU_WB   = 5'd8,
    ST_BR_EX    = 5'd9,
    ST_JAL_EX   = 5'd10,
    ST_JALR_EX  = 5'd11,
    ST_LINK_WB  = 5'd12,
    ST_LUI_WB   = 5'd13,
    ST_AUIPC_WB = 5'd14,
    ST_MUL_EX   = 5'd15,
    ST_TRAP     = 5'd16
  } state_e;

  // Instruction class produced by the opcode decoder
  typedef enum logic [3:0] {
    CL_LOAD, CL_STORE, CL_ALU_R, CL_MUL, CL_ALU_I, CL_BRANCH,
    CL_JAL, CL_JALR, CL_LUI, CL_AUIPC, CL_ILLEGAL
  } instr_class_e;

  // RV32I base opcodes
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Concat_control immediate-format selects; the store address path
  // reuses the I-format code on this datapath
  localparam logic [2:0] CC_NONE  = 3'b000;
  localparam logic [2:0] CC_U     = 3'b001;
  localparam logic [2:0] CC_J     = 3'b010;
  localparam logic [2:0] CC_I     = 3'b011;
  localparam logic [2:0] CC_B     = 3'b100;
  localparam logic [2:0] CC_LOAD  = 3'b101;
  localparam logic [2:0] CC_SHAMT = 3'b110;

  // Byte-enable encodings
  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Output bundle of the Moore decoder
  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src1;
    logic       alu_src2;
    logic       branch;
    logic       jump;
    logic       jal_or_jalr;
    logic [3:0] be;
    logic [2:0] concat_sel;
    logic       mul_start;
    logic       retire;
    logic       illegal;
  } ctrl_t;

  // Byte enables for a load/store size; BE_NONE marks an unsupported size
  function automatic logic [3:0] be_encode(input logic [2:0] funct3, input logic is_store);
    logic [3:0] be;
    case (funct3)
      3'b000:  be = BE_BYTE;
      3'b001:  be = BE_HALF;
      3'b010:  be = BE_WORD;
      3'b100:  be = is_store ? BE_NONE : BE_BYTE;
      3'b101:  be = is_store ? BE_NONE : BE_HALF;
      default: be = BE_NONE;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Instruction-field, handshake and control bundle between controller and datapath.
interface mc_control_unit_if #(parameter int unsigned CNT_W = 32) ();
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             funct7_0;
  logic             mem_ready;
  logic             mul_done;
  logic             PCWrite;
  logic             IRWrite;
  logic             MemRead;
  logic             MemWrite;
  logic             RegWrite;
  logic             RegDst;
  logic             MemtoReg;
  logic             ALUSrc1;
  logic             ALUSrc2;
  logic             Branch;
  logic             Jump;
  logic             JALorJALR;
  logic [3:0]       BE;
  logic [2:0]       Concat_control;
  logic [6:0]       ALUOp;
  logic             mul_start;
  logic             illegal;
  logic             retire;
  logic [CNT_W-1:0] retired_cnt;
  logic [4:0]       state_o;

  // Controller side
  modport master (
    input  opcode, funct3, funct7_0, mem_ready, mul_done,
    output PCWrite, IRWrite, MemRead, MemWrite, RegWrite,
    output RegDst, MemtoReg, ALUSrc1, ALUSrc2, Branch, Jump, JALorJALR,
    output BE, Concat_control, ALUOp, mul_start, illegal, retire,
    output retired_cnt, state_o
  );

  // Datapath side
  modport slave (
    output opcode, funct3, funct7_0, mem_ready, mul_done,
    input  PCWrite, IRWrite, MemRead, MemWrite, RegWrite,
    input  RegDst, MemtoReg, ALUSrc1, ALUSrc2, Branch, Jump, JALorJALR,
    input  BE, Concat_control, ALUOp, mul_start, illegal, retire,
    input  retired_cnt, state_o
  );
endinterface

// File: rtl/mc_control_unit_decode.sv
// Combinational opcode decoder: instruction class, illegal flag and
// load/store size legality.
module mc_opcode_decode
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned M_EXT = 0
) (
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic         funct7_0,
  output instr_class_e iclass,
  output logic         illegal,
  output logic         mem_size_ok
);

  // Map opcode (and funct7_0 for R-type) onto an instruction class
  always_comb begin
    iclass = CL_ILLEGAL;
    case (opcode)
      OPC_LOAD:   iclass = CL_LOAD;
      OPC_STORE:  iclass = CL_STORE;
      OPC_OP:     iclass = funct7_0 ? ((M_EXT != 0) ? CL_MUL : CL_ILLEGAL) : CL_ALU_R;
      OPC_OP_IMM: iclass = CL_ALU_I;
      OPC_BRANCH: iclass = CL_BRANCH;
      OPC_JAL:    iclass = CL_JAL;
      OPC_JALR:   iclass = CL_JALR;
      OPC_LUI:    iclass = CL_LUI;
      OPC_AUIPC:  iclass = CL_AUIPC;
      default:    iclass = CL_ILLEGAL;
    endcase
  end

  assign illegal = (iclass == CL_ILLEGAL);

  // Only meaningful for loads/stores; checked once the address is formed
  assign mem_size_ok = (be_encode(funct3, opcode == OPC_STORE) != BE_NONE);

endmodule

// File: rtl/mc_control_unit.sv
// Moore multicycle control unit for the RV32I CPU: sequences each instruction
// and drives every datapath enable from the registered state.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_HS = 1,
  parameter int unsigned M_EXT  = 0,
  parameter int unsigned CNT_W  = 32
) (
  input logic              CLK,
  input logic              RSTn,
  mc_control_unit_if.master bus
);

  state_e           state_reg;
  state_e           state_next;
  logic             mul_busy_reg;
  logic [CNT_W-1:0] retired_cnt_reg;

  instr_class_e     iclass;
  logic             dec_illegal;
  logic             mem_size_ok;
  logic             mem_done;
  logic             retire_now;
  ctrl_t            ctrl;
  ctrl_t            ctrl_out;

  mc_opcode_decode #(.M_EXT(M_EXT)) u_decode (
    .opcode      (bus.opcode),
    .funct3      (bus.funct3),
    .funct7_0    (bus.funct7_0),
    .iclass      (iclass),
    .illegal     (dec_illegal),
    .mem_size_ok (mem_size_ok)
  );

  // Without a handshake every memory access completes in one cycle
  assign mem_done = (MEM_HS == 0) ? 1'b1 : bus.mem_ready;

  // Instruction retires on the transition back into FETCH
  assign retire_now = (state_next == ST_FETCH) && (state_reg != ST_FETCH);

  // Next-state sequencing
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FETCH:    if (mem_done) state_next = ST_DECODE;
      ST_DECODE: begin
        if (dec_illegal) begin
          state_next = ST_TRAP;
        end else begin
          case (iclass)
            CL_LOAD, CL_STORE: state_next = ST_MEM_ADDR;
            CL_ALU_R:          state_next = ST_R_EX;
            CL_MUL:            state_next = ST_MUL_EX;
            CL_ALU_I:          state_next = ST_I_EX;
            CL_BRANCH:         state_next = ST_BR_EX;
            CL_JAL:            state_next = ST_JAL_EX;
            CL_JALR:           state_next = ST_JALR_EX;
            CL_LUI:            state_next = ST_LUI_WB;
            CL_AUIPC:          state_next = ST_AUIPC_WB;
            default:           state_next = ST_TRAP;
          endcase
        end
      end
      ST_MEM_ADDR: begin
        if (!mem_size_ok)            state_next = ST_TRAP;
        else if (iclass == CL_STORE) state_next = ST_MEM_WR;
        else                         state_next = ST_MEM_RD;
      end
      ST_MEM_RD:   if (mem_done) state_next = ST_LD_WB;
      ST_MEM_WR:   if (mem_done) state_next = ST_FETCH;
      ST_R_EX,
      ST_I_EX:     state_next = ST_ALU_WB;
      ST_MUL_EX:   if (bus.mul_done) state_next = ST_ALU_WB;
      ST_JAL_EX,
      ST_JALR_EX:  state_next = ST_LINK_WB;
      ST_BR_EX,
      ST_ALU_WB,
      ST_LD_WB,
      ST_LINK_WB,
      ST_LUI_WB,
      ST_AUIPC_WB: state_next = ST_FETCH;
      ST_TRAP:     state_next = ST_TRAP;
      default:     state_next = ST_TRAP;
    endcase
  end

  // State, multiplier-busy marker and retired-instruction counter
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_reg       <= ST_FETCH;
      mul_busy_reg    <= 1'b0;
      retired_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      // Set only while MUL_EX continues, so mul_start fires on entry alone
      mul_busy_reg <= (state_reg == ST_MUL_EX) && (state_next == ST_MUL_EX);
      if (retire_now) retired_cnt_reg <= retired_cnt_reg + CNT_W'(1);
    end
  end

  // Moore output decode from the registered state
  always_comb begin
    ctrl = '0;
    case (state_reg)
      ST_FETCH: begin
        ctrl.mem_read = 1'b1;
        ctrl.ir_write = mem_done;
        ctrl.pc_write = mem_done;
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src2   = 1'b1;
        ctrl.concat_sel = (iclass == CL_STORE) ? CC_I : CC_LOAD;
      end
      ST_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.be       = be_encode(bus.funct3, 1'b0);
      end
      ST_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.be        = be_encode(bus.funct3, 1'b1);
      end
      ST_I_EX: begin
        ctrl.alu_src2   = 1'b1;
        ctrl.concat_sel = (bus.funct3 == 3'b001 || bus.funct3 == 3'b101) ? CC_SHAMT : CC_I;
      end
      ST_BR_EX: begin
        ctrl.branch     = 1'b1;
        ctrl.concat_sel = CC_B;
      end
      ST_JAL_EX: begin
        ctrl.alu_src1   = 1'b1;
        ctrl.alu_src2   = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.concat_sel = CC_J;
      end
      ST_JALR_EX: begin
        ctrl.alu_src2    = 1'b1;
        ctrl.jump        = 1'b1;
        ctrl.jal_or_jalr = 1'b1;
        ctrl.concat_sel  = CC_I;
      end
      ST_LUI_WB,
      ST_AUIPC_WB: begin
        ctrl.alu_src1   = 1'b1;
        ctrl.alu_src2   = 1'b1;
        ctrl.concat_sel = CC_U;
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      ST_ALU_WB,
      ST_LINK_WB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      ST_LD_WB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MUL_EX: ctrl.mul_start = !mul_busy_reg;
      ST_TRAP:   ctrl.illegal   = 1'b1;
      default:   ctrl = '0;
    endcase
    ctrl.retire = retire_now;
  end

  // Nothing may be enabled while reset is held, even though state is FETCH
  assign ctrl_out = RSTn ? ctrl : '0;

  assign bus.PCWrite        = ctrl_out.pc_write;
  assign bus.IRWrite        = ctrl_out.ir_write;
  assign bus.MemRead        = ctrl_out.mem_read;
  assign bus.MemWrite       = ctrl_out.mem_write;
  assign bus.RegWrite       = ctrl_out.reg_write;
  assign bus.RegDst         = ctrl_out.reg_dst;
  assign bus.MemtoReg       = ctrl_out.mem_to_reg;
  assign bus.ALUSrc1        = ctrl_out.alu_src1;
  assign bus.ALUSrc2        = ctrl_out.alu_src2;
  assign bus.Branch         = ctrl_out.branch;
  assign bus.Jump           = ctrl_out.jump;
  assign bus.JALorJALR      = ctrl_out.jal_or_jalr;
  assign bus.BE             = ctrl_out.be;
  assign bus.Concat_control = ctrl_out.concat_sel;
  assign bus.mul_start      = ctrl_out.mul_start;
  assign bus.retire         = ctrl_out.retire;
  assign bus.illegal        = ctrl_out.illegal;
  assign bus.ALUOp          = bus.opcode;
  assign bus.retired_cnt    = retired_cnt_reg;
  assign bus.state_o        = state_reg;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed testbench for mc_control_unit: one single-cycle-memory instance
// without M extension, one handshaked instance with M extension.
module tb_mc_control_unit;
  import mc_ctrl_pkg::*;

  logic CLK = 1'b0;
  logic rst0_n;
  logic rst1_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 CLK = ~CLK;

  mc_control_unit_if #(.CNT_W(32)) b0 ();
  mc_control_unit_if #(.CNT_W(32)) b1 ();

  mc_control_unit #(.MEM_HS(0), .M_EXT(0), .CNT_W(32)) u0 (
    .CLK  (CLK),
    .RSTn (rst0_n),
    .bus  (b0)
  );

  mc_control_unit #(.MEM_HS(1), .M_EXT(1), .CNT_W(32)) u1 (
    .CLK  (CLK),
    .RSTn (rst1_n),
    .bus  (b1)
  );

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic reset_u0();
    rst0_n = 1'b0; tick(); rst0_n = 1'b1;
  endtask

  task automatic reset_u1();
    rst1_n = 1'b0; tick(); rst1_n = 1'b1;
  endtask

  task automatic test_reset();
    rst0_n = 1'b0; rst1_n = 1'b0;
    tick(); tick();
    @(negedge CLK);
    n_checks++; if (b0.state_o !== 5'd0) $display("FAIL rst_state0: got %0d want 0", b0.state_o); else n_pass++;
    n_checks++; if (b0.MemRead !== 1'b0) $display("FAIL rst_memread0: got %b want 0", b0.MemRead); else n_pass++;
    n_checks++; if (b0.retired_cnt !== 32'd0) $display("FAIL rst_cnt0: got %0d want 0", b0.retired_cnt); else n_pass++;
    n_checks++; if (b1.PCWrite !== 1'b0) $display("FAIL rst_pcwrite1: got %b want 0", b1.PCWrite); else n_pass++;
    n_checks++; if (b1.MemRead !== 1'b0) $display("FAIL rst_memread1: got %b want 0", b1.MemRead); else n_pass++;
    tick();
    rst1_n = 1'b1;
    // First fetch completes only on the first mem_ready after release
    for (int c = 0; c < 4; c++) begin
      b1.mem_ready = (c == 2);
      @(negedge CLK);
      n_checks++;
      if (b1.state_o !== ((c == 3) ? 5'd1 : 5'd0))
        $display("FAIL rst_wait_state[%0d]: got %0d want %0d", c, b1.state_o, (c == 3) ? 1 : 0);
      else n_pass++;
      if (c < 3) begin
        n_checks++;
        if (b1.IRWrite !== (c == 2)) $display("FAIL rst_wait_irwrite[%0d]: got %b want %b", c, b1.IRWrite, (c == 2));
        else n_pass++;
      end
      tick();
    end
    b1.mem_ready = 1'b0;
    $display("[tb] reset scenario done");
  endtask

  task automatic test_add();
    logic [4:0] exp_st [5];
    logic       exp_rw [5];
    exp_st = '{ST_FETCH, ST_DECODE, ST_R_EX, ST_ALU_WB, ST_FETCH};
    exp_rw = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    b0.opcode = OPC_OP; b0.funct3 = 3'b000; b0.funct7_0 = 1'b0;
    reset_u0();
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      n_checks++; if (b0.state_o !== exp_st[c]) $display("FAIL add_state[%0d]: got %0d want %0d", c, b0.state_o, exp_st[c]); else n_pass++;
      n_checks++; if (b0.RegWrite !== exp_rw[c]) $display("FAIL add_regwrite[%0d]: got %b want %b", c, b0.RegWrite, exp_rw[c]); else n_pass++;
      if (c == 4) begin
        n_checks++; if (b0.retired_cnt !== 32'd1) $display("FAIL add_cnt: got %0d want 1", b0.retired_cnt); else n_pass++;
      end
      tick();
    end
    $display("[tb] ADD transaction done");
  endtask

  task automatic test_lw_wait();
    logic [4:0] exp_st [9];
    logic       mr [9];
    logic       exp_mrd [9];
    logic       exp_m2r [9];
    exp_st  = '{ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_RD, ST_MEM_RD, ST_MEM_RD, ST_MEM_RD, ST_LD_WB, ST_FETCH};
    mr      = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_mrd = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_m2r = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    b1.opcode = OPC_LOAD; b1.funct3 = 3'b010; b1.funct7_0 = 1'b0; b1.mul_done = 1'b0;
    reset_u1();
    for (int c = 0; c < 9; c++) begin
      b1.mem_ready = mr[c];
      @(negedge CLK);
      n_checks++; if (b1.state_o !== exp_st[c]) $display("FAIL lw_state[%0d]: got %0d want %0d", c, b1.state_o, exp_st[c]); else n_pass++;
      n_checks++; if (b1.MemRead !== exp_mrd[c]) $display("FAIL lw_memread[%0d]: got %b want %b", c, b1.MemRead, exp_mrd[c]); else n_pass++;
      n_checks++; if (b1.MemtoReg !== exp_m2r[c]) $display("FAIL lw_memtoreg[%0d]: got %b want %b", c, b1.MemtoReg, exp_m2r[c]); else n_pass++;
      if (exp_st[c] == ST_MEM_RD) begin
        n_checks++; if (b1.BE !== 4'b1111) $display("FAIL lw_be[%0d]: got %b want 1111", c, b1.BE); else n_pass++;
      end
      if (c == 8) begin
        n_checks++; if (b1.retired_cnt !== 32'd1) $display("FAIL lw_cnt: got %0d want 1", b1.retired_cnt); else n_pass++;
      end
      tick();
    end
    $display("[tb] LW with memory wait done");
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_st [9];
    logic       exp_mw [9];
    logic [3:0] exp_be [9];
    exp_st = '{ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_WR, ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_WR, ST_FETCH};
    exp_mw = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_be = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 4'b0000};
    b0.opcode = OPC_STORE; b0.funct3 = 3'b000;
    reset_u0();
    for (int c = 0; c < 9; c++) begin
      b0.funct3 = (c < 4) ? 3'b000 : 3'b001;
      @(negedge CLK);
      n_checks++; if (b0.state_o !== exp_st[c]) $display("FAIL sbsh_state[%0d]: got %0d want %0d", c, b0.state_o, exp_st[c]); else n_pass++;
      n_checks++; if (b0.MemWrite !== exp_mw[c]) $display("FAIL sbsh_memwrite[%0d]: got %b want %b", c, b0.MemWrite, exp_mw[c]); else n_pass++;
      n_checks++; if (b0.BE !== exp_be[c]) $display("FAIL sbsh_be[%0d]: got %b want %b", c, b0.BE, exp_be[c]); else n_pass++;
      if (exp_st[c] == ST_MEM_ADDR) begin
        n_checks++; if (b0.Concat_control !== 3'b011) $display("FAIL sbsh_concat[%0d]: got %b want 011", c, b0.Concat_control); else n_pass++;
      end
      if (c == 8) begin
        n_checks++; if (b0.retired_cnt !== 32'd2) $display("FAIL sbsh_cnt: got %0d want 2", b0.retired_cnt); else n_pass++;
      end
      tick();
    end
    $display("[tb] SB then SH done");
  endtask

  task automatic test_trap();
    logic [4:0] exp_st [9];
    logic [4:0] exp_lw [5];
    exp_st = '{ST_FETCH, ST_DECODE, ST_LUI_WB, ST_FETCH, ST_DECODE, ST_TRAP, ST_TRAP, ST_TRAP, ST_TRAP};
    exp_lw = '{ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_TRAP, ST_TRAP};
    // LUI retires, then an all-zero opcode traps with the count frozen
    b0.opcode = OPC_LUI; b0.funct3 = 3'b000; b0.funct7_0 = 1'b0;
    reset_u0();
    for (int c = 0; c < 9; c++) begin
      b0.opcode = (c < 3) ? OPC_LUI : 7'b0000000;
      @(negedge CLK);
      n_checks++; if (b0.state_o !== exp_st[c]) $display("FAIL trap_state[%0d]: got %0d want %0d", c, b0.state_o, exp_st[c]); else n_pass++;
      n_checks++; if (b0.illegal !== (c >= 5)) $display("FAIL trap_illegal[%0d]: got %b want %b", c, b0.illegal, (c >= 5)); else n_pass++;
      if (c == 2) begin
        n_checks++; if (b0.RegWrite !== 1'b1) $display("FAIL lui_regwrite: got %b want 1", b0.RegWrite); else n_pass++;
        n_checks++; if (b0.Concat_control !== 3'b001) $display("FAIL lui_concat: got %b want 001", b0.Concat_control); else n_pass++;
        n_checks++; if (b0.ALUSrc1 !== 1'b1) $display("FAIL lui_alusrc1: got %b want 1", b0.ALUSrc1); else n_pass++;
      end
      if (c >= 5) begin
        n_checks++;
        if ({b0.PCWrite, b0.IRWrite, b0.MemRead, b0.MemWrite, b0.RegWrite} !== 5'b00000)
          $display("FAIL trap_enables[%0d]: got %b want 00000", c, {b0.PCWrite, b0.IRWrite, b0.MemRead, b0.MemWrite, b0.RegWrite});
        else n_pass++;
        n_checks++; if (b0.retired_cnt !== 32'd1) $display("FAIL trap_cnt[%0d]: got %0d want 1", c, b0.retired_cnt); else n_pass++;
      end
      tick();
    end
    // Unsupported load size traps from MEM_ADDR
    b0.opcode = OPC_LOAD; b0.funct3 = 3'b011;
    reset_u0();
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      n_checks++; if (b0.state_o !== exp_lw[c]) $display("FAIL lw011_state[%0d]: got %0d want %0d", c, b0.state_o, exp_lw[c]); else n_pass++;
      tick();
    end
    n_checks++; if (b0.illegal !== 1'b1) $display("FAIL lw011_illegal: got %b want 1", b0.illegal); else n_pass++;
    // MUL encoding without the M extension
    b0.opcode = OPC_OP; b0.funct3 = 3'b000; b0.funct7_0 = 1'b1;
    reset_u0();
    tick(); tick();
    @(negedge CLK);
    n_checks++; if (b0.state_o !== 5'd16) $display("FAIL mul_noext_state: got %0d want 16", b0.state_o); else n_pass++;
    n_checks++; if (b0.illegal !== 1'b1) $display("FAIL mul_noext_illegal: got %b want 1", b0.illegal); else n_pass++;
    tick();
    $display("[tb] trap scenarios done");
  endtask

  task automatic test_mul();
    logic [4:0] exp_st [10];
    logic       exp_ms [10];
    logic       exp_rt [10];
    exp_st = '{ST_FETCH, ST_DECODE, ST_MUL_EX, ST_MUL_EX, ST_MUL_EX, ST_MUL_EX, ST_MUL_EX, ST_MUL_EX, ST_ALU_WB, ST_FETCH};
    exp_ms = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_rt = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    b1.opcode = OPC_OP; b1.funct3 = 3'b000; b1.funct7_0 = 1'b1;
    reset_u1();
    for (int c = 0; c < 10; c++) begin
      b1.mem_ready = (c == 0);
      b1.mul_done  = (c == 7);
      @(negedge CLK);
      n_checks++; if (b1.state_o !== exp_st[c]) $display("FAIL mul_state[%0d]: got %0d want %0d", c, b1.state_o, exp_st[c]); else n_pass++;
      n_checks++; if (b1.mul_start !== exp_ms[c]) $display("FAIL mul_start[%0d]: got %b want %b", c, b1.mul_start, exp_ms[c]); else n_pass++;
      n_checks++; if (b1.retire !== exp_rt[c]) $display("FAIL mul_retire[%0d]: got %b want %b", c, b1.retire, exp_rt[c]); else n_pass++;
      if (c == 9) begin
        n_checks++; if (b1.retired_cnt !== 32'd1) $display("FAIL mul_cnt: got %0d want 1", b1.retired_cnt); else n_pass++;
      end
      tick();
    end
    b1.mul_done = 1'b0; b1.funct7_0 = 1'b0;
    $display("[tb] MUL transaction done");
  endtask

  task automatic test_reset_mid_store();
    logic [4:0] exp_st [8];
    exp_st = '{ST_FETCH, ST_DECODE, ST_LUI_WB, ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_WR, ST_MEM_WR};
    b1.opcode = OPC_LUI; b1.funct3 = 3'b010; b1.funct7_0 = 1'b0;
    reset_u1();
    for (int c = 0; c < 8; c++) begin
      b1.opcode    = (c < 3) ? OPC_LUI : OPC_STORE;
      b1.mem_ready = (c == 0) || (c == 3);
      @(negedge CLK);
      n_checks++; if (b1.state_o !== exp_st[c]) $display("FAIL rsw_state[%0d]: got %0d want %0d", c, b1.state_o, exp_st[c]); else n_pass++;
      if (c >= 6) begin
        n_checks++; if (b1.MemWrite !== 1'b1) $display("FAIL rsw_memwrite[%0d]: got %b want 1", c, b1.MemWrite); else n_pass++;
        n_checks++; if (b1.BE !== 4'b1111) $display("FAIL rsw_be[%0d]: got %b want 1111", c, b1.BE); else n_pass++;
      end
      if (c < 7) tick();
    end
    n_checks++; if (b1.retired_cnt !== 32'd1) $display("FAIL rsw_cnt_before: got %0d want 1", b1.retired_cnt); else n_pass++;
    // Drop reset mid-cycle, away from any clock edge
    #2 rst1_n = 1'b0;
    #1;
    n_checks++; if (b1.MemWrite !== 1'b0) $display("FAIL rsw_memwrite_async: got %b want 0", b1.MemWrite); else n_pass++;
    n_checks++; if (b1.state_o !== 5'd0) $display("FAIL rsw_state_async: got %0d want 0", b1.state_o); else n_pass++;
    n_checks++; if (b1.retired_cnt !== 32'd0) $display("FAIL rsw_cnt_async: got %0d want 0", b1.retired_cnt); else n_pass++;
    tick();
    rst1_n = 1'b1;
    b1.mem_ready = 1'b0;
    @(negedge CLK);
    n_checks++; if (b1.state_o !== 5'd0) $display("FAIL rsw_state_after: got %0d want 0", b1.state_o); else n_pass++;
    n_checks++; if (b1.MemWrite !== 1'b0) $display("FAIL rsw_memwrite_after: got %b want 0", b1.MemWrite); else n_pass++;
    n_checks++; if (b1.MemRead !== 1'b1) $display("FAIL rsw_memread_after: got %b want 1", b1.MemRead); else n_pass++;
    n_checks++; if (b1.retired_cnt !== 32'd0) $display("FAIL rsw_cnt_after: got %0d want 0", b1.retired_cnt); else n_pass++;
    tick();
    $display("[tb] reset during MEM_WR done");
  endtask

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0;
    b0.opcode = OPC_OP;  b0.funct3 = 3'b000; b0.funct7_0 = 1'b0; b0.mem_ready = 1'b0; b0.mul_done = 1'b0;
    b1.opcode = OPC_LUI; b1.funct3 = 3'b000; b1.funct7_0 = 1'b0; b1.mem_ready = 1'b0; b1.mul_done = 1'b0;
    test_reset();
    test_add();
    test_lw_wait();
    test_back_to_back();
    test_trap();
    test_mul();
    test_reset_mid_store();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
